dram_ctrl: RTL and testbench

- Bridges the core's single-beat memory request interface (mem_valid/mem_ready) to the synchronous data RAM port set (dram_wen/waddr/raddr/wdata/wstrb/rdata).
- Registers each request, decodes and checks it, issues the RAM access, then returns read data or write acknowledge with a fixed latency.
- Fully pipelined: accepts one request per cycle and responds strictly in order.

---
 rtl/configure_pkg.sv | 16 +
 rtl/dram_ctrl.sv | 74 +++++++
 tb/tb_dram_ctrl.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/configure_pkg.sv
// rtl/configure_pkg.sv - system configuration and data RAM request type
package configure;

    localparam int unsigned dram_depth = 10;
    localparam logic [31:0] dram_base  = 32'h0010_0000;

    typedef struct packed {
        logic        valid;
        logic        instr;
        logic        err;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } dram_req_t;

endpackage

// File: rtl/dram_ctrl.sv
// rtl/dram_ctrl.sv - core memory request bridge to the synchronous data RAM
module dram_ctrl
    import configure::dram_req_t;
#(
    parameter logic [31:0] dram_base  = configure::dram_base,
    parameter int unsigned dram_depth = configure::dram_depth
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_valid,
    input  logic                  mem_instr,
    input  logic [31:0]           mem_addr,
    input  logic [31:0]           mem_wdata,
    input  logic [3:0]            mem_wstrb,
    output logic [31:0]           mem_rdata,
    output logic                  mem_ready,
    output logic                  mem_error,
    output logic                  dram_wen,
    output logic [dram_depth-1:0] dram_waddr,
    output logic [dram_depth-1:0] dram_raddr,
    output logic [31:0]           dram_wdata,
    output logic [3:0]            dram_wstrb,
    input  logic [31:0]           dram_rdata
);

    localparam logic [31:0] window = 32'd4 << dram_depth;

    function automatic logic req_err(input logic [31:0] addr, input logic instr,
                                     input logic [3:0] wstrb);
        logic [31:0] offset;
        offset = addr - dram_base;
        return (offset >= window) | (addr[1:0] != 2'b00) | (instr & (wstrb != 4'b0000));
    endfunction

    dram_req_t q;
    dram_req_t r;
    logic [31:0] q_offset;
    logic        wen;
    logic        unused_bits;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
            r <= '0;
        end else begin
            q.valid <= mem_valid;
            if (mem_valid) begin
                q.instr <= mem_instr;
                q.err   <= req_err(mem_addr, mem_instr, mem_wstrb);
                q.addr  <= mem_addr;
                q.wdata <= mem_wdata;
                q.wstrb <= mem_wstrb;
            end
            r <= q;
        end
    end

    // Window base is aligned, so the offset's low bits are the RAM word index.
    assign q_offset   = q.addr - dram_base;
    assign wen        = q.valid & ~q.err & (q.wstrb != 4'b0000);
    assign dram_wen   = wen;
    assign dram_waddr = q_offset[dram_depth+1:2];
    assign dram_raddr = q_offset[dram_depth+1:2];
    assign dram_wdata = q.wdata;
    assign dram_wstrb = wen ? q.wstrb : 4'b0000;

    assign mem_ready = r.valid;
    assign mem_error = r.valid & r.err;
    assign mem_rdata = (r.valid && !r.err && r.wstrb == 4'b0000) ? dram_rdata : 32'd0;

    assign unused_bits = ^{q.instr, r.instr, r.addr, r.wdata,
                           q_offset[31:dram_depth+2], q_offset[1:0]};

endmodule

// File: tb/tb_dram_ctrl.sv
// tb/tb_dram_ctrl.sv - directed self-checking bench for dram_ctrl
module tb_dram_ctrl;
    import configure::*;

    localparam logic [31:0] win = 32'd4 << dram_depth;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  mem_valid = 1'b0;
    logic                  mem_instr = 1'b0;
    logic [31:0]           mem_addr = '0;
    logic [31:0]           mem_wdata = '0;
    logic [3:0]            mem_wstrb = '0;
    logic [31:0]           mem_rdata;
    logic                  mem_ready;
    logic                  mem_error;
    logic                  dram_wen;
    logic [dram_depth-1:0] dram_waddr;
    logic [dram_depth-1:0] dram_raddr;
    logic [31:0]           dram_wdata;
    logic [3:0]            dram_wstrb;
    logic [31:0]           dram_rdata = '0;

    always #5 clk = ~clk;

    dram_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .mem_valid  (mem_valid),
        .mem_instr  (mem_instr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .mem_error  (mem_error),
        .dram_wen   (dram_wen),
        .dram_waddr (dram_waddr),
        .dram_raddr (dram_raddr),
        .dram_wdata (dram_wdata),
        .dram_wstrb (dram_wstrb),
        .dram_rdata (dram_rdata)
    );

    logic [31:0] ram [2**dram_depth];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] ws);
        logic [31:0] w;
        w = old;
        for (int b = 0; b < 4; b++)
            if (ws[b]) w[8*b +: 8] = wd[8*b +: 8];
        return w;
    endfunction

    always @(posedge clk) begin
        if (dram_wen) ram[dram_waddr] <= merge(ram[dram_waddr], dram_wdata, dram_wstrb);
        dram_rdata <= ram[dram_raddr];
    end

    typedef struct {
        int          cyc;
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    resp_t got[$];
    resp_t exp[$];
    int    cyc = 0;
    bit    wen_seen = 1'b0;
    int    idle_bad = 0;
    int    errors = 0;
    int    checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_ready === 1'b1) got.push_back('{cyc, mem_rdata, mem_error});
        else if (rst && (mem_rdata !== 32'd0 || mem_error !== 1'b0)) idle_bad++;
        if (dram_wen === 1'b1) wen_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, req);
        end
    endtask

    task automatic issue(input logic instr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input logic [31:0] exp_rdata,
                         input logic exp_err, input bit expect_resp);
        mem_valid = 1'b1;
        mem_instr = instr;
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_wstrb = wstrb;
        if (expect_resp) exp.push_back('{cyc + 2, exp_rdata, exp_err});
        @(posedge clk);
        #1;
        mem_valid = 1'b0;
        mem_instr = 1'b0;
        mem_wstrb = 4'b0000;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input string tag);
        idle(4);
        check($sformatf("%s.count", tag), 32'(got.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            check($sformatf("%s[%0d].cyc", tag, i), 32'(got[i].cyc), 32'(exp[i].cyc));
            check($sformatf("%s[%0d].rdata", tag, i), got[i].rdata, exp[i].rdata);
            check($sformatf("%s[%0d].err", tag, i), 32'(got[i].err), 32'(exp[i].err));
        end
        got.delete();
        exp.delete();
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, ".ready"}, 32'(mem_ready), 32'd0);
        check({tag, ".error"}, 32'(mem_error), 32'd0);
        check({tag, ".rdata"}, mem_rdata, 32'd0);
        check({tag, ".wen"}, 32'(dram_wen), 32'd0);
        check({tag, ".wstrb"}, 32'(dram_wstrb), 32'd0);
        check({tag, ".waddr"}, 32'(dram_waddr), 32'd0);
        check({tag, ".raddr"}, 32'(dram_raddr), 32'd0);
        check({tag, ".wdata"}, dram_wdata, 32'd0);
    endtask

    initial begin
        #1 rst = 1'b0;
        @(negedge clk);
        check_zero_outputs("reset");
        @(posedge clk);
        #1 rst = 1'b1;
        idle(1);

        // write then immediate read of the same word
        issue(1'b0, dram_base + 32'h10, 32'hDEAD_BEEF, 4'b1111, 32'd0, 1'b0, 1'b1);
        issue(1'b0, dram_base + 32'h10, 32'd0, 4'b0000, 32'hDEAD_BEEF, 1'b0, 1'b1);
        drain("raw");

        // byte lane merge
        issue(1'b0, dram_base + 32'h20, 32'h1122_3344, 4'b1111, 32'd0, 1'b0, 1'b1);
        issue(1'b0, dram_base + 32'h20, 32'h0000_AA00, 4'b0010, 32'd0, 1'b0, 1'b1);
        issue(1'b0, dram_base + 32'h20, 32'd0, 4'b0000, 32'h1122_AA44, 1'b0, 1'b1);
        drain("byte");

        // range and alignment errors, none may write the RAM
        wen_seen = 1'b0;
        issue(1'b0, dram_base + win, 32'd0, 4'b0000, 32'd0, 1'b1, 1'b1);
        issue(1'b0, dram_base + 32'h2, 32'd0, 4'b0000, 32'd0, 1'b1, 1'b1);
        issue(1'b0, dram_base - 32'h4, 32'd0, 4'b0000, 32'd0, 1'b1, 1'b1);
        issue(1'b0, dram_base + win, 32'h5555_5555, 4'b1111, 32'd0, 1'b1, 1'b1);
        issue(1'b0, dram_base + win - 32'h4, 32'd0, 4'b0000, 32'd0, 1'b0, 1'b1);
        drain("range");
        check("range.no_wen", 32'(wen_seen), 32'd0);

        // fetch carrying strobes is rejected and leaves RAM intact
        issue(1'b0, dram_base + 32'h30, 32'hCAFE_F00D, 4'b1111, 32'd0, 1'b0, 1'b1);
        drain("fetch_setup");
        wen_seen = 1'b0;
        issue(1'b1, dram_base + 32'h30, 32'h1234_5678, 4'b1111, 32'd0, 1'b1, 1'b1);
        issue(1'b1, dram_base + 32'h30, 32'd0, 4'b0000, 32'hCAFE_F00D, 1'b0, 1'b1);
        issue(1'b0, dram_base + 32'h30, 32'd0, 4'b0000, 32'hCAFE_F00D, 1'b0, 1'b1);
        drain("fetch");
        check("fetch.no_wen", 32'(wen_seen), 32'd0);

        // streaming writes then streaming reads
        for (int i = 0; i < 8; i++)
            issue(1'b0, dram_base + 32'h100 + 32'(4 * i), 32'hA500_0000 | 32'(i * 'h0101),
                  4'b1111, 32'd0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++)
            issue(1'b0, dram_base + 32'h100 + 32'(4 * i), 32'd0, 4'b0000,
                  32'hA500_0000 | 32'(i * 'h0101), 1'b0, 1'b1);
        drain("burst");

        // reset with a read in flight
        issue(1'b0, dram_base + 32'h20, 32'd0, 4'b0000, 32'd0, 1'b0, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check_zero_outputs("midreset");
        @(posedge clk);
        #1 rst = 1'b1;
        idle(1);
        issue(1'b0, dram_base + 32'h10, 32'd0, 4'b0000, 32'hDEAD_BEEF, 1'b0, 1'b1);
        drain("post_reset");

        check("idle_outputs_zero", 32'(idle_bad), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
